branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Sits directly upstream of the two-bit-counter branch predictor. It tracks in-flight branch predictions between fetch and execute in a small in-order queue. At execute it compares each prediction with the resolved outcome, drives the predictor's ADDR/OUTCOME update, and raises a pipeline flush with a corrected PC on a mispredict.

Parameters:
DEPTH, 4, number of in-flight branch entries (power of two, 2..16)
IDX_BITS, 3, predictor table index width; the index is PC[IDX_BITS+1:2]

Ports:
CLOCK  input  1  system clock, rising edge
INIT  input  1  asynchronous active-high reset
F_VALID  input  1  fetch stage issues a conditional branch this cycle
F_PC  input  32  PC of the fetched branch
F_PREDICT  input  1  predictor's PREDICTION for that branch (1 = taken)
F_TARGET  input  32  target the fetch stage used if predicted taken
E_VALID  input  1  execute stage resolves the oldest in-flight branch
E_TAKEN  input  1  actual outcome
E_TARGET  input  32  actual taken target
FULL  output  1  queue holds DEPTH entries; fetch must stall branch issue
EMPTY  output  1  queue holds zero entries
UPD_VALID  output  1  predictor update strobe (one cycle)
UPD_ADDR  output  IDX_BITS  predictor index for update
UPD_OUTCOME  output  1  actual outcome for the predictor
FLUSH  output  1  one-cycle flush of IF/ID stages
REDIRECT_PC  output  32  corrected fetch PC, valid while FLUSH=1
MISPREDICTS  output  16  saturating mispredict counter
ERR  output  1  sticky protocol error

Behaviour:
- Reset (INIT=1, asynchronous): queue empty (rd/wr ptr = 0, count = 0), FULL=0, EMPTY=1, UPD_VALID=0, UPD_ADDR=0, UPD_OUTCOME=0, FLUSH=0, REDIRECT_PC=0, MISPREDICTS=0, ERR=0. Reset mid-operation discards all entries immediately.
- Entry contents: {PC, PREDICT, TARGET}. Push happens when F_VALID=1, FULL=0, and no flush is being generated this edge.
- F_VALID=1 while FULL=1: the push is dropped and ERR is set.
- Pop happens when E_VALID=1 and EMPTY=0. The entry popped is always the oldest (FIFO order).
- E_VALID=1 while EMPTY=0 is false (queue empty): ignored, ERR set, no outputs pulse.
- Mispredict condition: E_TAKEN != entry.PREDICT, or (E_TAKEN=1 and PREDICT=1 and E_TARGET != entry.TARGET).
- Output latency is one cycle. Outputs are registered at the pop edge and valid the following cycle:
  - UPD_VALID=1
  - UPD_ADDR = entry.PC[IDX_BITS+1:2]
  - UPD_OUTCOME = E_TAKEN
  - If mispredict: FLUSH=1 and REDIRECT_PC = E_TAKEN ? E_TARGET : entry.PC + 4 (32-bit wrap).
  - UPD_VALID and FLUSH are single-cycle pulses. REDIRECT_PC holds its last value when FLUSH=0.
- Mispredict at a pop edge: all younger entries are wrong-path. Count, rd ptr and wr ptr all go to 0, and any same-edge push is discarded.
- Simultaneous push and pop without mispredict: both take effect and count is unchanged. When FULL=1, a push is still refused even if a pop occurs in the same cycle.
- FULL and EMPTY are derived combinationally from the registered count.
- Pointers wrap modulo DEPTH.
- MISPREDICTS increments by 1 per mispredict and saturates at 16'hFFFF.
- ERR clears only on INIT.

Decomposition:
- Shared package/header holds the ENTRY_W constant (32+1+32), the PC_STEP constant (4), and the mispredict-compare function.
- One sub-module, branch_queue: a parameterised sync FIFO with push, pop and clear inputs and count/full/empty outputs.
- Compare, update and flush logic stays in the top module.

Test Plan:
- Reset, then push PC=0x100 with PREDICT=0; resolve E_TAKEN=0 -> next cycle UPD_VALID=1, UPD_ADDR=0, UPD_OUTCOME=0, FLUSH=0, MISPREDICTS=0.
- Push PC=0x104 with PREDICT=0; resolve E_TAKEN=1, E_TARGET=0x200 -> UPD_ADDR=1, UPD_OUTCOME=1, FLUSH=1, REDIRECT_PC=0x200, MISPREDICTS=1.
- Push 3 entries with the oldest PC=0x108, PREDICT=1, TARGET=0x300; resolve E_TAKEN=0 -> FLUSH=1, REDIRECT_PC=0x10C, EMPTY=1 next cycle (younger entries purged).
- Push 4 entries -> FULL=1; a 5th F_VALID -> dropped, ERR=1; resolve all four correctly in order -> UPD_ADDR sequence matches push order, EMPTY=1.
- Same-cycle push and correct pop with count=2 -> count stays 2. Same-cycle push and mispredicting pop -> count=0.
- Preload MISPREDICTS to 16'hFFFE via repeated mispredicts, then 3 more mispredicts -> holds at 16'hFFFF. Assert INIT mid-stream -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: queue entry layout and
// the prediction-versus-outcome compare.
package branch_resolve_unit_pkg;

    localparam int          ENTRY_W = 32 + 1 + 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic        predict;
        logic [31:0] target;
    } brq_entry_t;

    // A predicted-taken branch that resolves taken to a different target is
    // still a mispredict, because fetch has already followed the wrong target.
    function automatic logic is_mispredict(input brq_entry_t ent,
                                           input logic       taken,
                                           input logic [31:0] act_target);
        return (taken != ent.predict) ||
               (taken && ent.predict && (act_target != ent.target));
    endfunction

endpackage

// File: rtl/branch_resolve_unit_queue.sv
// In-order FIFO of in-flight branch entries with a single-cycle clear that
// overrides any same-edge push or pop.
module branch_queue
    import branch_resolve_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = ENTRY_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full  && !i_clear;
    assign w_do_pop  = i_pop  && !o_empty && !i_clear;

    // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap by overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks in-flight branch predictions, resolves them at execute, and drives
// the predictor update plus a flush/redirect on mispredict.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int IDX_BITS = 3
) (
    input  logic                CLOCK,
    input  logic                INIT,
    input  logic                F_VALID,
    input  logic [31:0]         F_PC,
    input  logic                F_PREDICT,
    input  logic [31:0]         F_TARGET,
    input  logic                E_VALID,
    input  logic                E_TAKEN,
    input  logic [31:0]         E_TARGET,
    output logic                FULL,
    output logic                EMPTY,
    output logic                UPD_VALID,
    output logic [IDX_BITS-1:0] UPD_ADDR,
    output logic                UPD_OUTCOME,
    output logic                FLUSH,
    output logic [31:0]         REDIRECT_PC,
    output logic [15:0]         MISPREDICTS,
    output logic                ERR
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    brq_entry_t           w_wr_entry;
    brq_entry_t           w_rd_entry;
    logic [ENTRY_W-1:0]   w_rd_data;
    logic [CNT_W-1:0]     w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_misp;
    logic                 w_push;
    logic                 w_push_err;
    logic                 w_pop_err;
    logic [31:0]          w_redirect;

    logic                 r_upd_vld_p1;
    logic [IDX_BITS-1:0]  r_upd_addr_p1;
    logic                 r_upd_outcome_p1;
    logic                 r_flush_p1;
    logic [31:0]          r_redirect_p1;
    logic [15:0]          r_misp_cnt;
    logic                 r_err;

    assign w_wr_entry = '{pc: F_PC, predict: F_PREDICT, target: F_TARGET};
    assign w_rd_entry = w_rd_data;

    assign w_pop      = E_VALID && (w_count != '0);
    assign w_misp     = w_pop && is_mispredict(w_rd_entry, E_TAKEN, E_TARGET);
    // A mispredict makes every younger entry wrong-path, including one arriving now.
    assign w_push     = F_VALID && !w_full && !w_misp;
    assign w_push_err = F_VALID && w_full;
    assign w_pop_err  = E_VALID && w_empty;
    assign w_redirect = E_TAKEN ? E_TARGET : (w_rd_entry.pc + PC_STEP);

    branch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .i_clk   (CLOCK),
        .i_rst   (INIT),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_misp),
        .i_wdata (w_wr_entry),
        .o_rdata (w_rd_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ---- p0 -> p1: resolve result registered, visible the cycle after the pop
    always_ff @(posedge CLOCK or posedge INIT) begin
        if (INIT) begin
            r_upd_vld_p1     <= 1'b0;
            r_upd_addr_p1    <= '0;
            r_upd_outcome_p1 <= 1'b0;
            r_flush_p1       <= 1'b0;
            r_redirect_p1    <= '0;
            r_misp_cnt       <= '0;
            r_err            <= 1'b0;
        end else begin
            r_upd_vld_p1 <= w_pop;
            r_flush_p1   <= w_misp;
            if (w_pop) begin
                r_upd_addr_p1    <= w_rd_entry.pc[IDX_BITS+1:2];
                r_upd_outcome_p1 <= E_TAKEN;
            end
            if (w_misp) begin
                r_redirect_p1 <= w_redirect;
                r_misp_cnt    <= sat_inc16(r_misp_cnt);
            end
            r_err <= r_err || w_push_err || w_pop_err;
        end
    end

    assign FULL        = w_full;
    assign EMPTY       = w_empty;
    assign UPD_VALID   = r_upd_vld_p1;
    assign UPD_ADDR    = r_upd_addr_p1;
    assign UPD_OUTCOME = r_upd_outcome_p1;
    assign FLUSH       = r_flush_p1;
    assign REDIRECT_PC = r_redirect_p1;
    assign MISPREDICTS = r_misp_cnt;
    assign ERR         = r_err;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (DEPTH=4, IDX_BITS=3).
module tb_branch_resolve_unit;

    logic        CLOCK = 1'b0;
    logic        INIT;
    logic        F_VALID;
    logic [31:0] F_PC;
    logic        F_PREDICT;
    logic [31:0] F_TARGET;
    logic        E_VALID;
    logic        E_TAKEN;
    logic [31:0] E_TARGET;
    logic        FULL;
    logic        EMPTY;
    logic        UPD_VALID;
    logic [2:0]  UPD_ADDR;
    logic        UPD_OUTCOME;
    logic        FLUSH;
    logic [31:0] REDIRECT_PC;
    logic [15:0] MISPREDICTS;
    logic        ERR;

    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_unit #(.DEPTH(4), .IDX_BITS(3)) dut (
        .CLOCK       (CLOCK),
        .INIT        (INIT),
        .F_VALID     (F_VALID),
        .F_PC        (F_PC),
        .F_PREDICT   (F_PREDICT),
        .F_TARGET    (F_TARGET),
        .E_VALID     (E_VALID),
        .E_TAKEN     (E_TAKEN),
        .E_TARGET    (E_TARGET),
        .FULL        (FULL),
        .EMPTY       (EMPTY),
        .UPD_VALID   (UPD_VALID),
        .UPD_ADDR    (UPD_ADDR),
        .UPD_OUTCOME (UPD_OUTCOME),
        .FLUSH       (FLUSH),
        .REDIRECT_PC (REDIRECT_PC),
        .MISPREDICTS (MISPREDICTS),
        .ERR         (ERR)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Stimulus tasks start and end at a falling edge.
    task automatic step();
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    task automatic do_push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        F_VALID = 1'b1; F_PC = pc; F_PREDICT = pred; F_TARGET = tgt;
        step();
        F_VALID = 1'b0;
    endtask

    task automatic do_resolve(input logic taken, input logic [31:0] tgt);
        E_VALID = 1'b1; E_TAKEN = taken; E_TARGET = tgt;
        step();
        E_VALID = 1'b0;
    endtask

    task automatic do_both(input logic [31:0] pc, input logic pred, input logic [31:0] ftgt,
                           input logic taken, input logic [31:0] etgt);
        F_VALID = 1'b1; F_PC = pc; F_PREDICT = pred; F_TARGET = ftgt;
        E_VALID = 1'b1; E_TAKEN = taken; E_TARGET = etgt;
        step();
        F_VALID = 1'b0;
        E_VALID = 1'b0;
    endtask

    task automatic apply_reset();
        INIT = 1'b1;
        step();
        step();
        INIT = 1'b0;
        step();
    endtask

    task automatic test_reset();
        INIT = 1'b1; F_VALID = 1'b0; F_PC = '0; F_PREDICT = 1'b0; F_TARGET = '0;
        E_VALID = 1'b0; E_TAKEN = 1'b0; E_TARGET = '0;
        step();
        step();
        n_checks++; if (EMPTY !== 1'b1) begin n_errors++; $display("FAIL reset_empty got %0b want 1", EMPTY); end
        n_checks++; if (FULL !== 1'b0) begin n_errors++; $display("FAIL reset_full got %0b want 0", FULL); end
        n_checks++; if ({UPD_VALID, UPD_ADDR, UPD_OUTCOME, FLUSH} !== 6'b0) begin
            n_errors++; $display("FAIL reset_upd got %b want 000000", {UPD_VALID, UPD_ADDR, UPD_OUTCOME, FLUSH}); end
        n_checks++; if (REDIRECT_PC !== 32'h0) begin n_errors++; $display("FAIL reset_redirect got %h want 0", REDIRECT_PC); end
        n_checks++; if (MISPREDICTS !== 16'h0) begin n_errors++; $display("FAIL reset_misp got %h want 0", MISPREDICTS); end
        n_checks++; if (ERR !== 1'b0) begin n_errors++; $display("FAIL reset_err got %0b want 0", ERR); end
        INIT = 1'b0;
        step();
    endtask

    task automatic test_correct_predict();
        do_push(32'h100, 1'b0, 32'h0);
        n_checks++; if (EMPTY !== 1'b0) begin n_errors++; $display("FAIL cp_empty got %0b want 0", EMPTY); end
        do_resolve(1'b0, 32'h0);
        n_checks++; if (UPD_VALID !== 1'b1) begin n_errors++; $display("FAIL cp_upd_vld got %0b want 1", UPD_VALID); end
        n_checks++; if (UPD_ADDR !== 3'd0) begin n_errors++; $display("FAIL cp_upd_addr got %0d want 0", UPD_ADDR); end
        n_checks++; if (UPD_OUTCOME !== 1'b0) begin n_errors++; $display("FAIL cp_outcome got %0b want 0", UPD_OUTCOME); end
        n_checks++; if (FLUSH !== 1'b0) begin n_errors++; $display("FAIL cp_flush got %0b want 0", FLUSH); end
        n_checks++; if (MISPREDICTS !== 16'd0) begin n_errors++; $display("FAIL cp_misp got %0d want 0", MISPREDICTS); end
        step();
        n_checks++; if (UPD_VALID !== 1'b0) begin n_errors++; $display("FAIL cp_upd_pulse got %0b want 0", UPD_VALID); end
    endtask

    task automatic test_mispredict_taken();
        do_push(32'h104, 1'b0, 32'h0);
        do_resolve(1'b1, 32'h200);
        n_checks++; if (UPD_ADDR !== 3'd1) begin n_errors++; $display("FAIL mt_upd_addr got %0d want 1", UPD_ADDR); end
        n_checks++; if (UPD_OUTCOME !== 1'b1) begin n_errors++; $display("FAIL mt_outcome got %0b want 1", UPD_OUTCOME); end
        n_checks++; if (FLUSH !== 1'b1) begin n_errors++; $display("FAIL mt_flush got %0b want 1", FLUSH); end
        n_checks++; if (REDIRECT_PC !== 32'h200) begin n_errors++; $display("FAIL mt_redirect got %h want 200", REDIRECT_PC); end
        n_checks++; if (MISPREDICTS !== 16'd1) begin n_errors++; $display("FAIL mt_misp got %0d want 1", MISPREDICTS); end
        step();
        n_checks++; if (FLUSH !== 1'b0) begin n_errors++; $display("FAIL mt_flush_pulse got %0b want 0", FLUSH); end
        n_checks++; if (REDIRECT_PC !== 32'h200) begin n_errors++; $display("FAIL mt_redirect_hold got %h want 200", REDIRECT_PC); end
    endtask

    task automatic test_purge();
        do_push(32'h108, 1'b1, 32'h300);
        do_push(32'h300, 1'b0, 32'h0);
        do_push(32'h304, 1'b0, 32'h0);
        do_resolve(1'b0, 32'h0);
        n_checks++; if (FLUSH !== 1'b1) begin n_errors++; $display("FAIL pg_flush got %0b want 1", FLUSH); end
        n_checks++; if (REDIRECT_PC !== 32'h10C) begin n_errors++; $display("FAIL pg_redirect got %h want 10c", REDIRECT_PC); end
        n_checks++; if (UPD_ADDR !== 3'd2) begin n_errors++; $display("FAIL pg_upd_addr got %0d want 2", UPD_ADDR); end
        n_checks++; if (EMPTY !== 1'b1) begin n_errors++; $display("FAIL pg_empty got %0b want 1", EMPTY); end
        n_checks++; if (MISPREDICTS !== 16'd2) begin n_errors++; $display("FAIL pg_misp got %0d want 2", MISPREDICTS); end
    endtask

    task automatic test_full_err();
        logic [31:0] pcs [4];
        pcs[0] = 32'h120; pcs[1] = 32'h124; pcs[2] = 32'h128; pcs[3] = 32'h12C;
        for (int i = 0; i < 4; i++) do_push(pcs[i], 1'b0, 32'h0);
        n_checks++; if (FULL !== 1'b1) begin n_errors++; $display("FAIL fe_full got %0b want 1", FULL); end
        n_checks++; if (ERR !== 1'b0) begin n_errors++; $display("FAIL fe_err_pre got %0b want 0", ERR); end
        do_push(32'h130, 1'b0, 32'h0);
        n_checks++; if (ERR !== 1'b1) begin n_errors++; $display("FAIL fe_err got %0b want 1", ERR); end
        n_checks++; if (FULL !== 1'b1) begin n_errors++; $display("FAIL fe_full_hold got %0b want 1", FULL); end
        for (int i = 0; i < 4; i++) begin
            do_resolve(1'b0, 32'h0);
            n_checks++;
            if (UPD_VALID !== 1'b1 || UPD_ADDR !== 3'(i) || FLUSH !== 1'b0) begin
                n_errors++;
                $display("FAIL fe_order%0d got vld=%0b addr=%0d flush=%0b want vld=1 addr=%0d flush=0",
                         i, UPD_VALID, UPD_ADDR, FLUSH, i);
            end
        end
        n_checks++; if (EMPTY !== 1'b1) begin n_errors++; $display("FAIL fe_empty got %0b want 1", EMPTY); end
        n_checks++; if (MISPREDICTS !== 16'd2) begin n_errors++; $display("FAIL fe_misp got %0d want 2", MISPREDICTS); end
    endtask

    task automatic test_empty_pop();
        apply_reset();
        do_resolve(1'b1, 32'h700);
        n_checks++; if (ERR !== 1'b1) begin n_errors++; $display("FAIL ep_err got %0b want 1", ERR); end
        n_checks++; if (UPD_VALID !== 1'b0 || FLUSH !== 1'b0) begin
            n_errors++; $display("FAIL ep_pulse got vld=%0b flush=%0b want 0 0", UPD_VALID, FLUSH); end
        n_checks++; if (MISPREDICTS !== 16'd0) begin n_errors++; $display("FAIL ep_misp got %0d want 0", MISPREDICTS); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_push(32'h140, 1'b0, 32'h0);
        do_push(32'h144, 1'b0, 32'h0);
        do_both(32'h148, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++; if (UPD_VALID !== 1'b1 || UPD_ADDR !== 3'd0) begin
            n_errors++; $display("FAIL bb_pop got vld=%0b addr=%0d want 1 0", UPD_VALID, UPD_ADDR); end
        n_checks++; if (FULL !== 1'b0 || EMPTY !== 1'b0) begin
            n_errors++; $display("FAIL bb_cnt2 got full=%0b empty=%0b want 0 0", FULL, EMPTY); end
        do_push(32'h14C, 1'b0, 32'h0);
        n_checks++; if (FULL !== 1'b0) begin n_errors++; $display("FAIL bb_cnt3 got full=%0b want 0", FULL); end
        do_push(32'h150, 1'b0, 32'h0);
        n_checks++; if (FULL !== 1'b1) begin n_errors++; $display("FAIL bb_cnt4 got full=%0b want 1", FULL); end
        // Push while full is refused even though a pop frees a slot this edge.
        do_both(32'h160, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++; if (FULL !== 1'b0 || UPD_ADDR !== 3'd1 || ERR !== 1'b1) begin
            n_errors++; $display("FAIL bb_full_pop got full=%0b addr=%0d err=%0b want 0 1 1", FULL, UPD_ADDR, ERR); end
        do_resolve(1'b0, 32'h0);
        n_checks++; if (UPD_ADDR !== 3'd2) begin n_errors++; $display("FAIL bb_pop_c got %0d want 2", UPD_ADDR); end
        do_both(32'h170, 1'b0, 32'h0, 1'b1, 32'h400);
        n_checks++; if (FLUSH !== 1'b1 || REDIRECT_PC !== 32'h400 || UPD_ADDR !== 3'd3) begin
            n_errors++; $display("FAIL bb_misp got flush=%0b pc=%h addr=%0d want 1 400 3", FLUSH, REDIRECT_PC, UPD_ADDR); end
        n_checks++; if (EMPTY !== 1'b1) begin n_errors++; $display("FAIL bb_purge got empty=%0b want 1", EMPTY); end
    endtask

    task automatic test_saturation();
        force dut.r_misp_cnt = 16'hFFFE;
        #1;
        release dut.r_misp_cnt;
        @(negedge CLOCK);
        n_checks++; if (MISPREDICTS !== 16'hFFFE) begin n_errors++; $display("FAIL sat_preload got %h want fffe", MISPREDICTS); end
        for (int i = 0; i < 3; i++) begin
            do_push(32'h180, 1'b0, 32'h0);
            do_resolve(1'b1, 32'h500);
            n_checks++;
            if (MISPREDICTS !== 16'hFFFF || FLUSH !== 1'b1) begin
                n_errors++; $display("FAIL sat_%0d got cnt=%h flush=%0b want ffff 1", i, MISPREDICTS, FLUSH); end
        end
    endtask

    task automatic test_async_reset();
        do_push(32'h1C0, 1'b0, 32'h0);
        do_push(32'h1C4, 1'b0, 32'h0);
        do_resolve(1'b0, 32'h0);
        n_checks++; if (UPD_VALID !== 1'b1 || EMPTY !== 1'b0 || ERR !== 1'b1) begin
            n_errors++; $display("FAIL ar_pre got vld=%0b empty=%0b err=%0b want 1 0 1", UPD_VALID, EMPTY, ERR); end
        #2;
        INIT = 1'b1;
        #1;
        n_checks++; if (UPD_VALID !== 1'b0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin
            n_errors++; $display("FAIL ar_queue got vld=%0b empty=%0b full=%0b want 0 1 0", UPD_VALID, EMPTY, FULL); end
        n_checks++; if (MISPREDICTS !== 16'h0 || ERR !== 1'b0 || REDIRECT_PC !== 32'h0 || FLUSH !== 1'b0) begin
            n_errors++; $display("FAIL ar_regs got cnt=%h err=%0b pc=%h flush=%0b want 0 0 0 0",
                                 MISPREDICTS, ERR, REDIRECT_PC, FLUSH); end
        n_checks++; if (UPD_ADDR !== 3'd0 || UPD_OUTCOME !== 1'b0) begin
            n_errors++; $display("FAIL ar_upd got addr=%0d out=%0b want 0 0", UPD_ADDR, UPD_OUTCOME); end
        @(negedge CLOCK);
        INIT = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_correct_predict();
        test_mispredict_taken();
        test_purge();
        test_full_err();
        test_empty_pop();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
